interrupt_controller: RTL and testbench

- Sits directly upstream of the game processor.
- Arbitrates two interrupt sources, the frame timer (generated internally by a divider) and keyboard key-valid strobes, onto the processor's INT_IRQ[1:0] code.
- Runs a request/acknowledge/end-of-interrupt handshake against INT_IACK/INT_IEND.
- Holds the keyboard data stable until the processor has latched it.

---
 rtl/intc_pkg.sv | 23 ++
 rtl/intc_tick_gen.sv | 31 +++
 rtl/interrupt_controller.sv | 148 ++++++++++++++
 tb/tb_interrupt_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared IRQ codes, FSM state and source encodings for the interrupt controller.
package intc_pkg;

  localparam logic [1:0] IRQ_TIMER = 2'b00;
  localparam logic [1:0] IRQ_KBD   = 2'b01;
  localparam logic [1:0] IRQ_NONE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_t;

  typedef enum logic {
    SRC_TMR = 1'b0,
    SRC_KBD = 1'b1
  } intc_src_t;

  function automatic logic [1:0] irq_code(input intc_src_t src);
    return (src == SRC_KBD) ? IRQ_KBD : IRQ_TIMER;
  endfunction

endpackage

// File: rtl/intc_tick_gen.sv
// Frame-timer divider: TICK is high for the one cycle in which the count wraps.
module intc_tick_gen #(
  parameter int TIMER_DIV = 833333,
  parameter int TIMER_W   = 20
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic ENABLE,
  output logic TICK
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMER_DIV - 1);

  logic [TIMER_W-1:0] r_cnt;
  logic               w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
    end else if (!ENABLE || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TIMER_W'(1);
    end
  end

  assign TICK = ENABLE & w_wrap;

endmodule

// File: rtl/interrupt_controller.sv
// Arbitrates frame-timer and keyboard interrupts onto INT_IRQ with an IACK/IEND handshake.
// Optional build macro INTC_OVR_COUNT_EN adds the saturating OVR_COUNT output.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int TIMER_DIV   = 833333,
  parameter int TIMER_W     = 20,
  parameter int SVC_TIMEOUT = 65535,
  parameter int TO_W        = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       KBD_VALID,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  output logic [1:0] INT_IRQ,
  output logic       KBD_HOLD,
  output logic       OVERRUN,
  output logic       HS_TIMEOUT
`ifdef INTC_OVR_COUNT_EN
  ,
  output logic [7:0] OVR_COUNT
`endif
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SVC_TIMEOUT - 1);

  intc_state_t     r_state, w_next_state;
  intc_src_t       r_src, w_next_src;
  logic            r_tmr_pend, r_kbd_pend;
  logic [TO_W-1:0] r_to_cnt;
  logic [1:0]      r_irq;
  logic            r_overrun, r_hs_timeout;

  logic w_tick, w_ack, w_to_hit, w_timeout;
  logic w_tmr_clr, w_kbd_clr, w_kbd_in_svc, w_kbd_set;
  logic w_kbd_ovr, w_tmr_ovr;

  intc_tick_gen #(
    .TIMER_DIV(TIMER_DIV),
    .TIMER_W  (TIMER_W)
  ) u_tick_gen (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .ENABLE (ENABLE),
    .TICK   (w_tick)
  );

  assign w_ack        = (r_state == REQ) & INT_IACK;
  assign w_to_hit     = (r_to_cnt == TO_LAST);
  assign w_tmr_clr    = w_ack & (r_src == SRC_TMR);
  assign w_kbd_clr    = w_ack & (r_src == SRC_KBD);
  assign w_kbd_in_svc = (r_state == SERVICE) & (r_src == SRC_KBD);

  // A key arriving while its predecessor is in service is folded into that service.
  assign w_kbd_set = KBD_VALID & ~w_kbd_in_svc;
  assign w_kbd_ovr = KBD_VALID & ((r_kbd_pend & ~w_kbd_clr) | w_kbd_in_svc);
  assign w_tmr_ovr = w_tick & r_tmr_pend & ~w_tmr_clr;

  always_comb begin
    w_next_state = r_state;
    w_next_src   = r_src;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_kbd_pend) begin
          w_next_state = REQ;
          w_next_src   = SRC_KBD;
        end else if (r_tmr_pend) begin
          w_next_state = REQ;
          w_next_src   = SRC_TMR;
        end
      end
      REQ: begin
        if (w_ack) begin
          w_next_state = SERVICE;
        end else if (w_to_hit) begin
          w_next_state = IDLE;
          w_timeout    = 1'b1;
        end
      end
      SERVICE: begin
        if (INT_IEND) begin
          w_next_state = IDLE;
        end else if (w_to_hit) begin
          w_next_state = IDLE;
          w_timeout    = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= IDLE;
      r_src        <= SRC_TMR;
      r_tmr_pend   <= 1'b0;
      r_kbd_pend   <= 1'b0;
      r_to_cnt     <= '0;
      r_irq        <= IRQ_NONE;
      r_overrun    <= 1'b0;
      r_hs_timeout <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_src      <= w_next_src;
      r_tmr_pend <= w_tick | (r_tmr_pend & ~w_tmr_clr);
      r_kbd_pend <= w_kbd_set | (r_kbd_pend & ~w_kbd_clr);
      if (w_next_state != r_state) begin
        r_to_cnt <= '0;
      end else if (r_state != IDLE) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      // The code is shown only while the request persists, so it drops on the IACK/timeout edge.
      r_irq <= ((r_state == REQ) && (w_next_state == REQ)) ? irq_code(r_src) : IRQ_NONE;
      if (w_kbd_ovr || w_tmr_ovr) begin
        r_overrun <= 1'b1;
      end
      if (w_timeout) begin
        r_hs_timeout <= 1'b1;
      end
    end
  end

`ifdef INTC_OVR_COUNT_EN
  logic [7:0] r_ovr_cnt;
  logic [8:0] w_ovr_sum;

  assign w_ovr_sum = {1'b0, r_ovr_cnt} + 9'(w_kbd_ovr) + 9'(w_tmr_ovr);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ovr_cnt <= '0;
    end else begin
      r_ovr_cnt <= (w_ovr_sum > 9'd255) ? 8'hFF : w_ovr_sum[7:0];
    end
  end

  assign OVR_COUNT = r_ovr_cnt;
`endif

  assign INT_IRQ    = r_irq;
  assign KBD_HOLD   = r_kbd_pend | ((r_state != IDLE) & (r_src == SRC_KBD));
  assign OVERRUN    = r_overrun;
  assign HS_TIMEOUT = r_hs_timeout;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a cycle model checked on every falling edge.
module tb_interrupt_controller;

  localparam int TDIV = 10;
  localparam int STO  = 20;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       ENABLE = 1'b0;
  logic       KBD_VALID = 1'b0;
  logic       INT_IACK = 1'b0;
  logic       INT_IEND = 1'b0;
  logic [1:0] INT_IRQ;
  logic       KBD_HOLD, OVERRUN, HS_TIMEOUT;
`ifdef INTC_OVR_COUNT_EN
  logic [7:0] OVR_COUNT;
`endif

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  interrupt_controller #(
    .TIMER_DIV  (TDIV),
    .TIMER_W    (4),
    .SVC_TIMEOUT(STO),
    .TO_W       (5)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .ENABLE    (ENABLE),
    .KBD_VALID (KBD_VALID),
    .INT_IACK  (INT_IACK),
    .INT_IEND  (INT_IEND),
    .INT_IRQ   (INT_IRQ),
    .KBD_HOLD  (KBD_HOLD),
    .OVERRUN   (OVERRUN),
    .HS_TIMEOUT(HS_TIMEOUT)
`ifdef INTC_OVR_COUNT_EN
    ,
    .OVR_COUNT (OVR_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Model: phase 0 = idle, 1 = requesting, 2 = in service; age = cycles spent in the phase.
  int m_div = 0;
  bit m_tp = 0, m_kp = 0, m_srck = 0, m_ovr = 0, m_to = 0;
  int m_ph = 0, m_age = 0, m_ocnt = 0;

  always @(posedge CLK or negedge RESET_N) begin : mdl
    bit tick, acked, kclr, tclr, ok, ot, kset;
    if (!RESET_N) begin
      m_div = 0; m_tp = 0; m_kp = 0; m_srck = 0; m_ovr = 0; m_to = 0;
      m_ph = 0; m_age = 0; m_ocnt = 0;
    end else begin
      tick  = ENABLE && (m_div == TDIV - 1);
      m_div = ENABLE ? (m_div + 1) % TDIV : 0;
      acked = (m_ph == 1) && INT_IACK;
      kclr  = acked && m_srck;
      tclr  = acked && !m_srck;
      ok    = KBD_VALID && ((m_kp && !kclr) || (m_ph == 2 && m_srck));
      ot    = tick && m_tp && !tclr;
      kset  = KBD_VALID && !(m_ph == 2 && m_srck);
      case (m_ph)
        0: begin
          if (m_kp || m_tp) begin
            m_ph = 1; m_srck = m_kp; m_age = 0;
          end
        end
        1: begin
          if (INT_IACK) begin m_ph = 2; m_age = 0; end
          else if (m_age == STO - 1) begin m_ph = 0; m_to = 1; end
          else m_age++;
        end
        default: begin
          if (INT_IEND) m_ph = 0;
          else if (m_age == STO - 1) begin m_ph = 0; m_to = 1; end
          else m_age++;
        end
      endcase
      m_kp = kset || (m_kp && !kclr);
      m_tp = tick || (m_tp && !tclr);
      if (ok || ot) m_ovr = 1;
      m_ocnt = m_ocnt + int'(ok) + int'(ot);
      if (m_ocnt > 255) m_ocnt = 255;
    end
  end

  always @(negedge CLK) begin
    logic [1:0] exp_irq;
    if (run_cmp) begin
      exp_irq = (m_ph == 1 && m_age >= 1) ? (m_srck ? 2'b01 : 2'b00) : 2'b11;
      chk("cmp_irq", 8'(INT_IRQ), 8'(exp_irq));
      chk("cmp_hold", 8'(KBD_HOLD), 8'(m_kp || (m_ph != 0 && m_srck)));
      chk("cmp_overrun", 8'(OVERRUN), 8'(m_ovr));
      chk("cmp_hs_timeout", 8'(HS_TIMEOUT), 8'(m_to));
`ifdef INTC_OVR_COUNT_EN
      chk("cmp_ovr_count", OVR_COUNT, 8'(m_ocnt));
`endif
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic strobe_kbd();
    KBD_VALID = 1'b1; step(); KBD_VALID = 1'b0;
  endtask

  task automatic pulse_iack();
    INT_IACK = 1'b1; step(); INT_IACK = 1'b0;
  endtask

  task automatic pulse_iend();
    INT_IEND = 1'b1; step(); INT_IEND = 1'b0;
  endtask

  initial begin
    #3 RESET_N = 1'b0;
    #1;
    chk("reset_irq", 8'(INT_IRQ), 8'h03);
    chk("reset_hold", 8'(KBD_HOLD), 8'h00);
    chk("reset_overrun", 8'(OVERRUN), 8'h00);
    chk("reset_hs_timeout", 8'(HS_TIMEOUT), 8'h00);
    repeat (3) step();
    RESET_N = 1'b1;
    run_cmp = 1'b1;
    step();

    // Keyboard path: IRQ appears two edges after the strobe.
    strobe_kbd();
    chk("kbd_hold_at_strobe", 8'(KBD_HOLD), 8'h01);
    chk("kbd_irq_n", 8'(INT_IRQ), 8'h03);
    step();
    chk("kbd_irq_n1", 8'(INT_IRQ), 8'h03);
    step();
    chk("kbd_irq_n2", 8'(INT_IRQ), 8'h01);
    repeat (2) step();
    pulse_iack();
    chk("kbd_irq_after_iack", 8'(INT_IRQ), 8'h03);
    chk("kbd_hold_in_service", 8'(KBD_HOLD), 8'h01);
    repeat (4) step();
    pulse_iend();
    chk("kbd_hold_after_iend", 8'(KBD_HOLD), 8'h00);
    chk("kbd_overrun", 8'(OVERRUN), 8'h00);
    repeat (2) step();

    // Priority: key strobe on the same edge as a timer tick.
    ENABLE = 1'b1;
    repeat (9) step();
    KBD_VALID = 1'b1; step(); KBD_VALID = 1'b0;
    ENABLE = 1'b0;
    step(); step();
    chk("prio_kbd_first", 8'(INT_IRQ), 8'h01);
    pulse_iack();
    pulse_iend();
    chk("prio_gap0", 8'(INT_IRQ), 8'h03);
    step();
    chk("prio_gap1", 8'(INT_IRQ), 8'h03);
    step();
    chk("prio_timer_next", 8'(INT_IRQ), 8'h00);
    chk("prio_hold_low", 8'(KBD_HOLD), 8'h00);
    pulse_iack();
    pulse_iend();
    repeat (2) step();

    // Overrun: second key while the first is still pending.
    strobe_kbd();
    step();
    strobe_kbd();
    chk("ovr_flag", 8'(OVERRUN), 8'h01);
    chk("ovr_irq", 8'(INT_IRQ), 8'h01);
`ifdef INTC_OVR_COUNT_EN
    chk("ovr_count_one", OVR_COUNT, 8'h01);
`endif
    pulse_iack();
    pulse_iend();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ovr_single_request", 8'(INT_IRQ), 8'h03);
    end

    // Timer held off, then re-enabled and left unacknowledged until timeout.
    for (int i = 0; i < 50; i++) begin
      step();
      chk("disabled_no_irq", 8'(INT_IRQ), 8'h03);
    end
    ENABLE = 1'b1;
    repeat (10) step();
    ENABLE = 1'b0;
    step();
    chk("enable_irq_k11", 8'(INT_IRQ), 8'h03);
    step();
    chk("enable_irq_k12", 8'(INT_IRQ), 8'h00);
    repeat (18) step();
    chk("to_still_req", 8'(INT_IRQ), 8'h00);
    chk("to_flag_before", 8'(HS_TIMEOUT), 8'h00);
    step();
    chk("to_irq_dropped", 8'(INT_IRQ), 8'h03);
    chk("to_flag_set", 8'(HS_TIMEOUT), 8'h01);
    step();
    chk("to_gap", 8'(INT_IRQ), 8'h03);
    step();
    chk("to_reraise", 8'(INT_IRQ), 8'h00);
    pulse_iack();
    pulse_iend();
    repeat (2) step();

    // Asynchronous reset while servicing a key.
    strobe_kbd();
    step(); step();
    pulse_iack();
    chk("rst_pre_hold", 8'(KBD_HOLD), 8'h01);
    RESET_N = 1'b0;
    #1;
    chk("rst_async_irq", 8'(INT_IRQ), 8'h03);
    chk("rst_async_hold", 8'(KBD_HOLD), 8'h00);
    chk("rst_async_overrun", 8'(OVERRUN), 8'h00);
    chk("rst_async_hs_timeout", 8'(HS_TIMEOUT), 8'h00);
`ifdef INTC_OVR_COUNT_EN
    chk("rst_async_ovr_count", OVR_COUNT, 8'h00);
`endif
    step(); step();
    RESET_N = 1'b1;
    step();
    pulse_iend();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_iend_ignored", 8'(INT_IRQ), 8'h03);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
